// File: rtl/axis_averager.sv
// axis_averager: block averager on an AXI-Stream link.
// Sums 2^L signed samples (L = log_count clamped to 16, captured at the start
// of each block), then emits floor(sum / 2^L) one cycle after the last sample.
// The output register is a single-entry skid-free stage: upstream is stalled
// only while a result is waiting and downstream is not ready.
//
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   log_count[4:0]         log2 of block length (values > 16 act as 16)
//   S_AXIS_tvalid/tready/tdata  sample input
//   M_AXIS_tvalid/tready/tdata  averaged output
module axis_averager #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [4:0]                  log_count,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

  localparam int W     = AXIS_TDATA_WIDTH;
  localparam int ACC_W = W + 16;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] avg;
  logic [16:0]             cnt;
  logic [4:0]              l_reg;
  logic [4:0]              l_clamp;
  logic [4:0]              l_eff;
  logic                    first;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    last;

  assign l_clamp = (log_count > 5'd16) ? 5'd16 : log_count;
  assign first   = (cnt == '0);
  // The first sample of a block uses the live log_count; later samples use
  // the value latched on that first sample, so mid-block changes are ignored.
  assign l_eff   = first ? l_clamp : l_reg;

  assign S_AXIS_tready = ~areset & (~M_AXIS_tvalid | M_AXIS_tready);
  assign in_xfer       = S_AXIS_tvalid & S_AXIS_tready;
  assign out_xfer      = M_AXIS_tvalid & M_AXIS_tready;

  // 16 guard bits hold 2^16 full-scale samples without overflow.
  assign sum  = acc + {{16{S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
  // Arithmetic shift of a signed value rounds toward minus infinity.
  assign avg  = sum >>> l_eff;
  assign last = in_xfer & (cnt == ((17'd1 << l_eff) - 17'd1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc           <= '0;
      cnt           <= '0;
      l_reg         <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
    end else begin
      if (in_xfer && first) l_reg <= l_clamp;
      if (last) begin
        acc           <= '0;
        cnt           <= '0;
        M_AXIS_tdata  <= avg[W-1:0];
        // Stays high even if the previous result leaves this cycle: the new
        // result replaces it without a bubble.
        M_AXIS_tvalid <= 1'b1;
      end else begin
        if (in_xfer) begin
          acc <= sum;
          cnt <= cnt + 17'd1;
        end
        if (out_xfer) M_AXIS_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_averager.sv
module tb_axis_averager;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [4:0]  log_count = '0;
  logic        S_AXIS_tvalid = 1'b0;
  logic        S_AXIS_tready;
  logic [31:0] S_AXIS_tdata = '0;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready = 1'b1;
  logic [31:0] M_AXIS_tdata;

  int tests = 0;
  int fails = 0;

  axis_averager #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .log_count(log_count),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready), .S_AXIS_tdata(S_AXIS_tdata),
    .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the list of samples' running sum for the current block and
  // produces floor(sum / 2^L) by integer division with explicit flooring.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  longint      blk_sum = 0;
  int          blk_cnt = 0;
  int          blk_L   = 0;
  logic [31:0] mlog[$];   // model output results
  logic [31:0] got[$];    // observed DUT output transfers
  int          vcount = 0;

  initial begin
    longint d, q;
    bit     rdy, done;
    forever begin
      @(posedge aclk);
      if (areset) begin
        m_valid = 0; m_data = 0; blk_sum = 0; blk_cnt = 0; blk_L = 0;
      end else begin
        rdy  = !m_valid || M_AXIS_tready;
        done = 0;
        if (S_AXIS_tvalid && rdy) begin
          if (blk_cnt == 0) blk_L = (log_count > 16) ? 16 : int'(log_count);
          blk_sum += longint'($signed(S_AXIS_tdata));
          blk_cnt++;
          if (blk_cnt == (1 << blk_L)) begin
            d = longint'(1) << blk_L;
            q = blk_sum / d;
            if (blk_sum < 0 && (blk_sum % d) != 0) q = q - 1;
            m_data  = q[31:0];
            m_valid = 1;
            mlog.push_back(m_data);
            blk_sum = 0;
            blk_cnt = 0;
            done    = 1;
          end
        end
        if (!done && m_valid && M_AXIS_tready) m_valid = 0;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  initial begin
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      chk("s_tready", S_AXIS_tready, (!areset && (!m_valid || M_AXIS_tready)));
      chk("m_tvalid", M_AXIS_tvalid, m_valid);
      chk("m_tdata", M_AXIS_tdata, m_data);
      if (!areset && M_AXIS_tvalid && M_AXIS_tready) got.push_back(M_AXIS_tdata);
      if (!areset && M_AXIS_tvalid) vcount++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] d);
    bit r;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = d;
    for (int t = 0; ; t++) begin
      @(negedge aclk);
      r = S_AXIS_tready;
      @(posedge aclk); #1;
      if (r) break;
      if (t > 50) begin chk("send_timeout", 0, 1); break; end
    end
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    S_AXIS_tvalid = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    got.delete(); mlog.delete(); vcount = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", M_AXIS_tvalid, 0);
    chk("rst_tdata", M_AXIS_tdata, 0);
    chk("rst_tready", S_AXIS_tready, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_tready", S_AXIS_tready, 1);

    // T1: N=4, 1,2,3,6 -> 3, valid for exactly one cycle right after 4th sample
    do_reset();
    log_count = 5'd2;
    send(1); send(2); send(3);
    chk("t1_no_early", M_AXIS_tvalid, 0);
    send(6);
    chk("t1_lat", M_AXIS_tvalid, 1);
    idle(1);
    chk("t1_drop", M_AXIS_tvalid, 0);
    idle(2);
    chk("t1_cnt", got.size(), 1);
    if (got.size() > 0) chk("t1_val", longint'(got[0]), 3);
    if (mlog.size() > 0) chk("t1_model", longint'(mlog[0]), 3);
    chk("t1_vcycles", vcount, 1);

    // T2: N=2, -1,-2 -> floor(-1.5) = -2
    do_reset();
    log_count = 5'd1;
    send(32'hFFFFFFFF); send(32'hFFFFFFFE);
    idle(2);
    chk("t2_cnt", got.size(), 1);
    if (got.size() > 0) chk("t2_val", longint'(got[0]), longint'(32'hFFFFFFFE));
    if (mlog.size() > 0) chk("t2_model", longint'(mlog[0]), longint'(32'hFFFFFFFE));

    // T3: N=1 pass-through at full rate
    do_reset();
    log_count = 5'd0;
    send(5);
    chk("t3_v1", M_AXIS_tvalid, 1);
    chk("t3_d1", M_AXIS_tdata, 5);
    send(6);
    chk("t3_d2", M_AXIS_tdata, 6);
    send(7);
    chk("t3_d3", M_AXIS_tdata, 7);
    chk("t3_v3", M_AXIS_tvalid, 1);
    idle(2);
    chk("t3_cnt", got.size(), 3);
    if (got.size() == 3) begin
      chk("t3_o0", longint'(got[0]), 5);
      chk("t3_o1", longint'(got[1]), 6);
      chk("t3_o2", longint'(got[2]), 7);
    end
    chk("t3_vcycles", vcount, 3);

    // T4: backpressure holds result and stalls input
    do_reset();
    log_count = 5'd1;
    M_AXIS_tready = 1'b0;
    send(10); send(20);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_hold_v", M_AXIS_tvalid, 1);
      chk("t4_hold_d", M_AXIS_tdata, 15);
      chk("t4_stall", S_AXIS_tready, 0);
      @(posedge aclk); #1;
    end
    M_AXIS_tready = 1'b1;
    @(negedge aclk);
    chk("t4_release_rdy", S_AXIS_tready, 1);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t4_after_v", M_AXIS_tvalid, 0);
    chk("t4_after_rdy", S_AXIS_tready, 1);
    chk("t4_cnt", got.size(), 1);
    if (got.size() > 0) chk("t4_val", longint'(got[0]), 15);

    // T5: reset mid-block discards partial sum
    do_reset();
    log_count = 5'd2;
    send(100); send(100); send(100);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    send(4); send(4); send(4); send(4);
    idle(2);
    chk("t5_cnt", got.size(), 1);
    if (got.size() > 0) chk("t5_val", longint'(got[0]), 4);

    // T6: gaps in tvalid do not matter; 1,-4,7,-5 -> floor(-1/4) = -1
    do_reset();
    log_count = 5'd2;
    send(1); idle(2);
    send(32'hFFFFFFFC); idle(1);
    send(7); idle(3);
    send(32'hFFFFFFFB);
    idle(2);
    chk("t6_cnt", got.size(), 1);
    if (got.size() > 0) chk("t6_val", longint'(got[0]), longint'(32'hFFFFFFFF));
    if (mlog.size() > 0) chk("t6_model", longint'(mlog[0]), longint'(32'hFFFFFFFF));

    // T7: log_count=20 clamps to 16; mid-block change to 0 ignored
    do_reset();
    log_count = 5'd20;
    send(32'h7FFFFFFF);
    log_count = 5'd0;
    for (int i = 1; i < 65535; i++) send(32'h7FFFFFFF);
    chk("t7_no_early", got.size(), 0);
    chk("t7_no_early_v", M_AXIS_tvalid, 0);
    send(32'h7FFFFFFF);
    chk("t7_lat", M_AXIS_tvalid, 1);
    idle(2);
    chk("t7_cnt", got.size(), 1);
    if (got.size() > 0) chk("t7_val", longint'(got[0]), longint'(32'h7FFFFFFF));
    if (mlog.size() > 0) chk("t7_model", longint'(mlog[0]), longint'(32'h7FFFFFFF));
    // next block uses the new log_count=0
    send(9);
    chk("t7_next_v", M_AXIS_tvalid, 1);
    chk("t7_next_d", M_AXIS_tdata, 9);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_averager.md
AXIS_AVERAGER -- requirements
Module: axis_averager

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, giving the sample width as two's-complement signed data.
REQ-002 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port log_count, input, 5 bits: log2 of the block length N; values above 16 are clamped to 16.
REQ-005 The block SHALL have port S_AXIS_tvalid, input, 1 bit: upstream sample valid.
REQ-006 The block SHALL have port S_AXIS_tready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 The block SHALL have port S_AXIS_tdata, input, AXIS_TDATA_WIDTH bits: upstream sample.
REQ-008 The block SHALL have port M_AXIS_tvalid, output, 1 bit: averaged sample valid; feeds the axis_throttler slave port.
REQ-009 The block SHALL have port M_AXIS_tready, input, 1 bit: downstream accepts the averaged sample.
REQ-010 The block SHALL have port M_AXIS_tdata, output, AXIS_TDATA_WIDTH bits: averaged sample.

Function
REQ-011 An input transfer SHALL occur on a cycle with S_AXIS_tvalid and S_AXIS_tready both high; an output transfer SHALL occur on a cycle with M_AXIS_tvalid and M_AXIS_tready both high.
REQ-012 S_AXIS_tready SHALL be driven combinationally as the logical OR of (not M_AXIS_tvalid) and M_AXIS_tready, gated low while areset is high.
REQ-013 The accumulator SHALL be AXIS_TDATA_WIDTH+16 bits, signed, and SHALL sign-extend every accepted sample before adding it, so that no overflow occurs for any N up to 65536.
REQ-014 The sample counter SHALL be 17 bits and SHALL increment by one on every input transfer.
REQ-015 The effective length shift L SHALL be captured from the clamped log_count on the first input transfer of each block (counter equal to 0) and held for the rest of that block.
REQ-016 Changes to log_count in mid-block SHALL be ignored until the next block starts.
REQ-017 On the input transfer where the counter equals 2^L-1, the block SHALL compute (accumulator + sample) arithmetically shifted right by L, rounding toward minus infinity.
REQ-018 The low AXIS_TDATA_WIDTH bits of that result SHALL be registered into M_AXIS_tdata, M_AXIS_tvalid SHALL be set, and the accumulator and counter SHALL both be cleared on the same edge.
REQ-019 Latency SHALL be one cycle: M_AXIS_tvalid rises on the edge following the final input transfer of a block.
REQ-020 With L equal to 0, the block SHALL act as a one-cycle registered pass-through at full rate.
REQ-021 While M_AXIS_tvalid is high and M_AXIS_tready is low, M_AXIS_tdata and M_AXIS_tvalid SHALL hold stable, and no input transfer SHALL occur.
REQ-022 When an output transfer and a block completion occur on the same cycle, the new result SHALL replace the old one and M_AXIS_tvalid SHALL stay high, with no bubble and no lost sample.
REQ-023 When an output transfer occurs with no block completion, M_AXIS_tvalid SHALL clear on the next edge.
REQ-024 On cycles with no input transfer, the accumulator and counter SHALL hold their values; gaps in S_AXIS_tvalid SHALL NOT affect the result.

Reset
REQ-025 While areset is high at a clock edge, the block SHALL clear the accumulator, counter, L, M_AXIS_tdata and M_AXIS_tvalid to 0.
REQ-026 A reset asserted mid-block SHALL discard the partial sum; the first input transfer after reset SHALL start a new block.
REQ-027 The block SHALL be fully operational on the first edge with areset low.

Verification
REQ-028 The bench SHALL cover: log_count=2, inputs 1,2,3,6 with M_AXIS_tready=1 -> a single output of 3, with M_AXIS_tvalid high for exactly 1 cycle, 1 cycle after the 4th sample.
REQ-029 The bench SHALL cover: log_count=1, inputs -1,-2 -> output -2 (32'hFFFFFFFE, floor of -1.5).
REQ-030 The bench SHALL cover: log_count=0 with a continuous input of 5,6,7 -> outputs 5,6,7 on consecutive cycles, each 1 cycle late, with S_AXIS_tready constantly high.
REQ-031 The bench SHALL cover: log_count=1, inputs 10,20 with M_AXIS_tready=0 for 5 cycles -> M_AXIS_tdata=15 held stable and S_AXIS_tready=0 throughout; releasing M_AXIS_tready gives one transfer and S_AXIS_tready returns high.
REQ-032 The bench SHALL cover: log_count=2, 3 samples of 100, then areset for 1 cycle, then 4,4,4,4 -> a single output of 4 and no output containing the 100s.
REQ-033 The bench SHALL cover: log_count=20 (clamped to 16), 65536 samples of 32'h7FFFFFFF -> output 32'h7FFFFFFF, and a change of log_count to 0 mid-block has no effect until the block ends.
